// File: rtl/prod_acc.sv
// ============================================================================
// Module   : prod_acc
// Purpose  : Adds up a programmed number of 16-bit multiplier products with
//            saturation and hands the sum downstream over a valid/ready link.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prod_acc #(
   parameter int ACC_W = 18,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             activate,
   input  logic [CNT_W-1:0] count,
   input  logic             endop,
   input  logic [7:0]       mult8,
   input  logic [7:0]       mult16,
   input  logic             sum_ready,
   output logic [ACC_W-1:0] sum,
   output logic             sum_valid,
   output logic             busy,
   output logic             ovf
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [ACC_W-1:0] sum_q;
   logic             sum_valid_q;
   logic             busy_q;
   logic             ovf_q;
   logic [CNT_W-1:0] rem_q;
   logic             endop_q;

   logic             accept_d;
   logic [ACC_W:0]   add_d;

   // A held strobe yields a single product: only its first cycle is accepted.
   assign accept_d = endop & ~endop_q;
   assign add_d    = {1'b0, sum_q} + {{(ACC_W-15){1'b0}}, mult16, mult8};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         sum_q       <= '0;
         sum_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
         rem_q       <= '0;
         endop_q     <= 1'b0;
      end else begin
         endop_q <= endop;
         case (state_q)
            ST_IDLE: begin
               if (activate) begin
                  sum_q  <= '0;
                  ovf_q  <= 1'b0;
                  busy_q <= 1'b1;
                  if (count != '0) begin
                     rem_q   <= count;
                     state_q <= ST_ACC;
                  end else begin
                     sum_valid_q <= 1'b1;
                     state_q     <= ST_DONE;
                  end
               end
            end
            ST_ACC: begin
               if (accept_d) begin
                  // A carry out of the accumulator pins the sum at all ones.
                  if (add_d[ACC_W]) begin
                     sum_q <= '1;
                     ovf_q <= 1'b1;
                  end else begin
                     sum_q <= add_d[ACC_W-1:0];
                  end
                  rem_q <= rem_q - CNT_W'(1);
                  if (rem_q == CNT_W'(1)) begin
                     sum_valid_q <= 1'b1;
                     state_q     <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (sum_ready) begin
                  sum_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               sum_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign sum       = sum_q;
   assign sum_valid = sum_valid_q;
   assign busy      = busy_q;
   assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: doc/prod_acc.md
Name: prod_acc

Overview:
- Downstream consumer of the sequential 8x8 multiplier.
- Captures each 16-bit product {mult16, mult8} when the multiplier signals end of operation, and accumulates a programmed number of products into a saturating accumulator.
- Presents the final sum to the next ALU stage with a valid/ready handshake.
- Provides the sum-of-products step for dot-product style sequences.

Parameters:
- ACC_W, 18, accumulator and sum width in bits; must be at least 16.
- CNT_W, 4, width of the product-count input.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; low clears all state immediately.
- activate  input  1  starts a new accumulation frame when sampled high in IDLE.
- count  input  CNT_W  number of products in the frame; sampled with activate.
- endop  input  1  multiplier end-of-operation strobe; may stay high for more than one cycle.
- mult8  input  8  low byte of the multiplier product.
- mult16  input  8  high byte of the multiplier product.
- sum_ready  input  1  downstream accepts sum while sum_valid=1.
- sum  output  ACC_W  accumulated result.
- sum_valid  output  1  sum is final and stable.
- busy  output  1  frame in progress, from accept of activate until the handshake completes.
- ovf  output  1  sticky saturation flag for the current frame.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, sum=0, sum_valid=0, busy=0, ovf=0.
  - Remaining-count register = 0; endop edge register = 0.
  - Reset asserted mid-frame aborts the frame; no partial result is presented.
- Product accept:
  - A product is accepted on a rising clk where endop=1 and registered endop_q=0 (rising-edge detect).
  - A strobe held high for N cycles counts once.
  - endop_q is updated every cycle in every state.
- IDLE:
  - busy=0, sum_valid=0; sum holds the last value.
  - activate=1 with count!=0: sum<=0, ovf<=0, remaining<=count, busy<=1, go to ACC.
  - activate=1 with count=0: sum<=0, ovf<=0, busy<=1, go to DONE; sum_valid=1 on the next cycle.
  - Accepted endop in IDLE is ignored.
- ACC:
  - On each accepted product: sum <= sum + zero-extended {mult16, mult8}, computed at ACC_W+1 bits.
  - If bit ACC_W of that result is 1: sum <= all ones, ovf <= 1 (sticky until the next frame start).
  - Once saturated, further adds keep all ones.
  - remaining decrements by 1 per accepted product.
  - Accepted product with remaining=1: go to DONE. sum_valid rises the cycle after the final accepted endop (latency 1).
  - activate in ACC is ignored; count is not resampled.
- DONE:
  - sum_valid=1, busy=1; sum and ovf are held stable.
  - sum_ready=1 at a rising edge: go to IDLE, sum_valid<=0, busy<=0.
  - sum_ready high in the same cycle sum_valid first rises completes the handshake on that edge.
  - activate and endop in DONE are ignored. A new frame requires a return to IDLE first, so activate is earliest effective one cycle after the handshake.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset: reset low while in ACC with sum=0x00123 -> sum=0, sum_valid=0, busy=0, ovf=0 with no clk edge; after release the block sits in IDLE.
- Basic frame: count=3, products 0x0006, 0x0100, 0xFFFF, each a 1-cycle endop -> sum=0x10105, ovf=0, sum_valid=1 one cycle after the 3rd endop; sum_ready=1 -> IDLE next cycle.
- Saturation: count=5, five products of 0xFFFF -> after the 5th, sum=0x3FFFF, ovf=1. Next frame with count=1 and product 0x0001 -> sum=0x00001, ovf=0.
- Long strobe: count=2, endop held high 4 cycles with 0x0010, then low, then a 1-cycle pulse with 0x0020 -> sum=0x00030 (first strobe counted once).
- Handshake backpressure: count=1, product 0x1234, sum_ready=0 for 5 cycles -> sum=0x01234 and sum_valid=1 held. Additional endop and activate pulses during the wait leave sum unchanged; sum_ready=1 -> sum_valid=0 next cycle.
- Zero count: activate with count=0 -> sum_valid=1 next cycle with sum=0, ovf=0. Activate pulsed during ACC of a count=2 frame does not restart it.
